hex_segment_decoder: RTL and testbench
======================================

# hex_segment_decoder

Receive-side counterpart of the team's hex display driver: samples an 8-bit active-low seven-segment bus and recovers the displayed hex nibble and decimal-point state. Used for loopback self-check of the board's HEX outputs and for reading segment buses from external display drivers. A stability filter rejects glitches and multiplex transitions. Unknown patterns are flagged and counted.

## Interface
- NUM_SEGMENTS, 8, segment bus width; bit 7 is DP, bits 6:0 are g..a.
- STABLE_CYCLES, 4, consecutive identical samples required before lock; legal range 2..255.
- clk  in  1  system clock.
- n_rst  in  1  asynchronous, active-low reset; one clock domain.
- ss_in  in  NUM_SEGMENTS  sampled segment bus; bits 6:0 active-low.
- sample_en  in  1  enables decoding; low forces IDLE.
- err_clr  in  1  synchronous clear of err_count.
- hex_char  out  4  last locked decoded nibble.
- dp  out  1  bit 7 of the last locked pattern, passed through without inversion.
- valid  out  1  high while LOCKED on a legal pattern.
- char_strobe  out  1  one-cycle pulse on each newly locked legal value.
- invalid_pattern  out  1  one-cycle pulse when a lock occurs on an illegal pattern.
- err_count  out  8  saturating count of invalid locks.

## Operation
- **Decode table** (bits 6:0, active-low gfedcba):
  - 0=40h, 1=79h, 2=24h, 3=30h, 4=19h, 5=12h, 6=02h, 7=78h
  - 8=00h, 9=10h, A=08h, b=03h, C=46h, d=21h, E=06h, F=0Eh
  - Every other 7-bit code is illegal.
- **Stability filter.** The filter tracks the current sample s and the previous sample p.
  - If s differs from p in any of the 8 bits, the counter loads 1.
  - Otherwise the counter increments, saturating at STABLE_CYCLES.
- **FSM states:**
  - IDLE: sample_en=0. Counter cleared. valid=0.
  - SETTLE: counter below STABLE_CYCLES.
  - LOCKED: pattern stable.
- **Transitions:**
  - IDLE→SETTLE when sample_en=1.
  - SETTLE→LOCKED when the counter reaches STABLE_CYCLES.
  - LOCKED→SETTLE on any change of s.
  - Any state→IDLE when sample_en=0.
- **Entering LOCKED with a legal code:**
  - hex_char and dp are registered; valid=1.
  - char_strobe pulses if this is the first lock since IDLE/reset or if {hex_char,dp} differs from the previous lock.
- **Entering LOCKED with an illegal code:**
  - hex_char and dp hold their previous values; valid=0.
  - invalid_pattern pulses.
  - err_count increments, saturating at FFh.
- **Leaving LOCKED:** valid drops on the edge that enters SETTLE; hex_char and dp hold.
- **err_count control:** err_clr clears err_count. err_clr asserted in the same cycle as an increment leaves err_count at 0 (clear wins).

## Timing
- **Reset values:** hex_char=0, dp=0, valid=0, char_strobe=0, invalid_pattern=0, err_count=0, FSM=IDLE, sample registers all-ones (blank display).
- **Edge numbering:** edge 1 is the first rising edge that samples a new ss_in value.
  - With the synchronizer, s takes the new value at edge 2.
  - Lock, and the valid/char_strobe/invalid_pattern update, occurs at edge 1+STABLE_CYCLES with the synchronizer and edge STABLE_CYCLES without it.
- **Glitch rejection:** a pattern held for fewer than STABLE_CYCLES samples never locks.
- **Output registration:** all outputs are registered with no combinational path from ss_in.
- **Reset mid-operation:** an asynchronous n_rst assertion immediately forces the reset values, including during a pulse cycle.

## Configuration
- **HEX_SEG_DECODER_SYNC_EN defined:** ss_in passes through a two-flop synchronizer before the filter, for asynchronous external buses.
- **Undefined:** ss_in is registered once and feeds the filter directly, for on-chip loopback. Latency is reduced by one edge.

## Structure
- **Package hex_seg_pkg:**
  - seg_t (logic [6:0]).
  - The 16-entry localparam decode table of seg_t.
  - A function seg_to_nibble returning {legal, nibble}.
  - The FSM enum decoder_state_t {IDLE, SETTLE, LOCKED}.
  - The constant DP_BIT=7.
- **Sub-module seg_stability_filter:** the optional synchronizer, s/p registers and counter, with a stable-level output. The FSM, decode and error counter stay in the top.

## Test plan
- **Legal lock:** sample_en=1, ss_in=A4h held 10 cycles, no sync, STABLE_CYCLES=4 → at edge 4: hex_char=2, dp=1, valid=1, char_strobe pulses once. No further strobe while held.
- **Glitch rejection:** from lock on 2, ss_in=30h for 2 cycles then back to A4h → valid drops for the settling interval and relocks on 2 with no char_strobe. 3 is never reported.
- **Illegal pattern:** ss_in=7Fh held 8 cycles → invalid_pattern pulses once, err_count=1, valid=0, hex_char unchanged.
- **Saturation and clear:** 257 illegal locks → err_count=FFh. err_clr together with a further illegal lock → err_count=0.
- **Disable:** sample_en=0 during LOCKED → valid=0 next edge. Re-enable with the same pattern → full STABLE_CYCLES relock and char_strobe pulses again (first lock).
- **Async reset:** n_rst pulsed low mid-SETTLE and during a char_strobe cycle → all outputs at reset values immediately.

Source files
------------

// File: rtl/hex_seg_pkg.sv
// Shared types, decode table and helpers for the seven-segment bus decoder.
package hex_seg_pkg;
  typedef logic [6:0] seg_t;

  localparam int DP_BIT = 7;

  // Active-low gfedcba patterns for nibbles 0..F.
  localparam seg_t SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic [1:0] {IDLE, SETTLE, LOCKED} decoder_state_t;

  // Returns {legal, nibble}; nibble is 0 for illegal codes.
  function automatic logic [4:0] seg_to_nibble(input seg_t seg);
    logic [4:0] r;
    r = '0;
    for (int i = 0; i < 16; i++)
      if (seg == SEG_TABLE[i]) r = {1'b1, i[3:0]};
    return r;
  endfunction
endpackage

// File: rtl/seg_stability_filter.sv
// Sample register, optional synchronizer (HEX_SEG_DECODER_SYNC_EN) and run-length counter.
module seg_stability_filter
  import hex_seg_pkg::*;
#(
  parameter int NUM_SEGMENTS  = 8,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    en,
  input  logic [NUM_SEGMENTS-1:0] ss_in,
  output logic [NUM_SEGMENTS-1:0] sample,
  output logic                    stable
);
  localparam logic [7:0] SC = 8'(STABLE_CYCLES);

  logic [NUM_SEGMENTS-1:0] s_in;
  logic [NUM_SEGMENTS-1:0] s_q;
  logic [7:0]              cnt, cnt_nxt;

`ifdef HEX_SEG_DECODER_SYNC_EN
  logic [NUM_SEGMENTS-1:0] meta;
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) meta <= '1;
    else        meta <= ss_in;
  assign s_in = meta;
`else
  assign s_in = ss_in;
`endif

  // Look ahead one edge so the lock lands on the edge that completes the run.
  always_comb begin
    cnt_nxt = cnt;
    if (s_in != s_q)   cnt_nxt = 8'd1;
    else if (cnt < SC) cnt_nxt = cnt + 8'd1;
  end

  assign stable = en && (cnt_nxt == SC);
  assign sample = s_q;

  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      s_q <= '1;
      cnt <= '0;
    end else begin
      s_q <= s_in;
      cnt <= en ? cnt_nxt : 8'd0;
    end
endmodule

// File: rtl/hex_segment_decoder.sv
// Recovers hex nibble and DP from an active-low segment bus with glitch filtering.
// Build with HEX_SEG_DECODER_SYNC_EN for asynchronous external buses.
module hex_segment_decoder
  import hex_seg_pkg::*;
#(
  parameter int NUM_SEGMENTS  = 8,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic [NUM_SEGMENTS-1:0] ss_in,
  input  logic                    sample_en,
  input  logic                    err_clr,
  output logic [3:0]              hex_char,
  output logic                    dp,
  output logic                    valid,
  output logic                    char_strobe,
  output logic                    invalid_pattern,
  output logic [7:0]              err_count
);
  decoder_state_t          state, state_nxt;
  logic [NUM_SEGMENTS-1:0] sample;
  logic                    stable, lock, legal, have_lock;
  logic [4:0]              dec;

  seg_stability_filter #(
    .NUM_SEGMENTS (NUM_SEGMENTS),
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_filter (
    .clk   (clk),
    .n_rst (n_rst),
    .en    (sample_en),
    .ss_in (ss_in),
    .sample(sample),
    .stable(stable)
  );

  always_comb begin
    state_nxt = state;
    if (!sample_en) state_nxt = IDLE;
    else
      case (state)
        IDLE:    state_nxt = SETTLE;
        SETTLE:  if (stable)  state_nxt = LOCKED;
        LOCKED:  if (!stable) state_nxt = SETTLE;
        default: state_nxt = IDLE;
      endcase
  end

  // Lock implies the sample register already holds the stable pattern.
  assign dec   = seg_to_nibble(sample[6:0]);
  assign legal = dec[4];
  assign lock  = (state != LOCKED) && (state_nxt == LOCKED);

  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) state <= IDLE;
    else        state <= state_nxt;

  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      hex_char        <= '0;
      dp              <= 1'b0;
      valid           <= 1'b0;
      char_strobe     <= 1'b0;
      invalid_pattern <= 1'b0;
      have_lock       <= 1'b0;
    end else begin
      char_strobe     <= 1'b0;
      invalid_pattern <= 1'b0;
      if (lock && legal) begin
        hex_char    <= dec[3:0];
        dp          <= sample[DP_BIT];
        valid       <= 1'b1;
        have_lock   <= 1'b1;
        char_strobe <= !have_lock || ({dec[3:0], sample[DP_BIT]} != {hex_char, dp});
      end else if (lock) begin
        valid           <= 1'b0;
        invalid_pattern <= 1'b1;
      end else if (state_nxt != LOCKED) begin
        valid <= 1'b0;
      end
      if (state_nxt == IDLE) have_lock <= 1'b0;
    end

  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst)                                 err_count <= '0;
    else if (err_clr)                           err_count <= '0;
    else if (lock && !legal && err_count != 8'hFF) err_count <= err_count + 8'd1;
endmodule

// File: tb/tb_hex_segment_decoder.sv
// Directed bench for hex_segment_decoder; pulse events are scoreboarded.
module tb_hex_segment_decoder;
  localparam int SC = 4;
`ifdef HEX_SEG_DECODER_SYNC_EN
  localparam int LAT = SC + 1;
`else
  localparam int LAT = SC;
`endif

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic [7:0] ss_in = 8'hFF;
  logic       sample_en = 1'b0;
  logic       err_clr = 1'b0;
  logic [3:0] hex_char;
  logic       dp, valid, char_strobe, invalid_pattern;
  logic [7:0] err_count;

  typedef struct {
    bit         inv;
    logic [3:0] nib;
    logic       dp;
    logic [7:0] err;
  } ev_t;

  ev_t        sb[$];
  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_err = 8'h00;

  hex_segment_decoder #(.NUM_SEGMENTS(8), .STABLE_CYCLES(SC)) dut (
    .clk            (clk),
    .n_rst          (n_rst),
    .ss_in          (ss_in),
    .sample_en      (sample_en),
    .err_clr        (err_clr),
    .hex_char       (hex_char),
    .dp             (dp),
    .valid          (valid),
    .char_strobe    (char_strobe),
    .invalid_pattern(invalid_pattern),
    .err_count      (err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_legal(input logic [3:0] nib, input logic d);
    sb.push_back('{inv: 1'b0, nib: nib, dp: d, err: exp_err});
  endtask

  task automatic push_illegal(input bit clr);
    if (clr)                  exp_err = 8'h00;
    else if (exp_err != 8'hFF) exp_err = exp_err + 8'd1;
    sb.push_back('{inv: 1'b1, nib: 4'h0, dp: 1'b0, err: exp_err});
  endtask

  // Every strobe/invalid pulse must match the next expected event.
  always @(negedge clk) begin
    if (n_rst && (char_strobe || invalid_pattern)) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", {char_strobe, invalid_pattern}, 2'b00);
      end else begin
        ev_t e;
        e = sb.pop_front();
        check("pulse_kind", {char_strobe, invalid_pattern}, e.inv ? 2'b01 : 2'b10);
        check("pulse_err", err_count, e.err);
        if (!e.inv) begin
          check("pulse_char", hex_char, e.nib);
          check("pulse_dp", dp, e.dp);
        end
      end
    end
  end

  initial begin
    // Reset state
    #12;
    check("rst_hex", hex_char, 4'h0);
    check("rst_flags", {dp, valid, char_strobe, invalid_pattern}, 4'b0000);
    check("rst_err", err_count, 8'h00);
    cyc(1);
    n_rst = 1'b1;
    cyc(2);

    // Legal lock on A4h (2 with DP)
    sample_en = 1'b1;
    ss_in     = 8'hA4;
    push_legal(4'h2, 1'b1);
    cyc(LAT - 1);
    check("lock_early_valid", valid, 1'b0);
    cyc(1);
    check("lock_valid", valid, 1'b1);
    check("lock_hex", hex_char, 4'h2);
    check("lock_dp", dp, 1'b1);
    cyc(6);
    check("hold_valid", valid, 1'b1);

    // Short 30h glitch must not lock, relock on the same value is silent
    ss_in = 8'h30;
    cyc(2);
    check("glitch_valid", valid, 1'b0);
    ss_in = 8'hA4;
    cyc(LAT - 1);
    check("relock_early", valid, 1'b0);
    cyc(1);
    check("relock_valid", valid, 1'b1);
    check("relock_hex", hex_char, 4'h2);

    // Illegal pattern
    ss_in = 8'h7F;
    push_illegal(1'b0);
    cyc(LAT);
    check("ill_err", err_count, 8'h01);
    check("ill_valid", valid, 1'b0);
    check("ill_hex", hex_char, 4'h2);
    cyc(8 - LAT);
    check("ill_hold_err", err_count, 8'h01);

    // 256 more illegal locks saturate the counter
    for (int i = 0; i < 256; i++) begin
      ss_in = (i % 2 == 0) ? 8'hFF : 8'h7F;
      push_illegal(1'b0);
      cyc(LAT);
    end
    check("sat_err", err_count, 8'hFF);

    // Clear coinciding with an illegal lock wins
    ss_in = 8'hFF;
    cyc(LAT - 1);
    err_clr = 1'b1;
    push_illegal(1'b1);
    cyc(1);
    err_clr = 1'b0;
    check("clr_err", err_count, 8'h00);

    // Same legal value as the last lock: no strobe
    ss_in = 8'hA4;
    cyc(LAT);
    check("same_valid", valid, 1'b1);

    // Disable drops valid; re-enable is a fresh first lock
    sample_en = 1'b0;
    cyc(1);
    check("dis_valid", valid, 1'b0);
    cyc(2);
    sample_en = 1'b1;
    push_legal(4'h2, 1'b1);
    cyc(SC - 1);
    check("reen_early", valid, 1'b0);
    cyc(1);
    check("reen_valid", valid, 1'b1);

    // New legal value strobes
    ss_in = 8'h06;
    push_legal(4'hE, 1'b0);
    cyc(LAT);
    check("e_hex", hex_char, 4'hE);
    check("e_dp", dp, 1'b0);

    // Async reset mid-settle
    ss_in = 8'h40;
    cyc(2);
    #2 n_rst = 1'b0;
    #1;
    check("rst_mid_hex", hex_char, 4'h0);
    check("rst_mid_valid", valid, 1'b0);
    cyc(1);
    n_rst = 1'b1;
    exp_err = 8'h00;

    // Async reset during the strobe cycle
    ss_in = 8'h79;
    push_legal(4'h1, 1'b0);
    cyc(LAT);
    check("pre_rst_hex", hex_char, 4'h1);
    #2 n_rst = 1'b0;
    #1;
    check("rst_pulse_strobe", char_strobe, 1'b0);
    check("rst_pulse_hex", hex_char, 4'h0);
    check("rst_pulse_valid", valid, 1'b0);
    cyc(1);
    n_rst = 1'b1;
    cyc(2);

    check("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
